// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline types: forwarding selects, mul/div FSM states, stage-register controls
// and the default mul/div latencies.
package pipeline_hazard_ctrl_pkg;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 32;
  localparam int DEFAULT_REG_AW      = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } FwdSel;

  typedef enum logic [0:0] {
    MD_RUN  = 1'b0,
    MD_BUSY = 1'b1
  } MdState;

  typedef struct packed {
    logic en;
    logic clr;
  } PipelineReg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_tracker.sv
// Mul/div busy tracker: a RUN/BUSY state machine with a down-counter that flags an
// operation in flight and pulses done on its final busy cycle.
module md_busy_tracker
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic issue,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
  localparam int CW         = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [0:0]    ST_RUN    = 1'(MD_RUN);
  localparam logic [0:0]    ST_BUSY   = 1'(MD_BUSY);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 2);

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;

  // The counter keeps running through pipeline freezes: the unit is independent of it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_RUN) begin
      if (issue) begin
        state_next = ST_BUSY;
        cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
      end
    end else begin
      if (cnt_reg == '0) begin
        state_next = ST_RUN;
      end else begin
        cnt_next = cnt_reg - CW'(1);
      end
    end
    done_next = (state_next == ST_BUSY) && (cnt_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg == ST_BUSY);
  assign done = done_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline stall/flush/forwarding controller.
// Define HAZARD_MULDIV_EN to include the multi-cycle mul/div busy tracker and hilo stall.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
  parameter int REG_AW      = DEFAULT_REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_hilo,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_reg_write,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              ex_md_start,
  input  logic              ex_md_is_div,
  input  logic              dmem_wait,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_clr,
  output logic              idex_clr,
  output logic              exmem_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              md_busy,
  output logic              md_done
);

  logic       load_use;
  logic       hilo_stall;
  logic       md_busy_int;
  logic       md_done_int;
  PipelineReg ifid, idex, exmem;
  logic       pc_en_int, memwb_en_int;

  // ex_reg_write is not needed: a load in EX always writes its destination.
  logic unused_inputs;
  assign unused_inputs = ex_reg_write;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));

`ifdef HAZARD_MULDIV_EN
  logic md_issue;
  // Only an instruction that actually leaves EX starts the unit.
  assign md_issue   = ex_md_start && !dmem_wait && !ex_branch_taken;
  assign hilo_stall = id_use_hilo && (md_busy_int || ex_md_start);

  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_tracker (
    .clock (clock),
    .reset (reset),
    .issue (md_issue),
    .is_div(ex_md_is_div),
    .busy  (md_busy_int),
    .done  (md_done_int)
  );
`else
  logic unused_md_is_div;
  assign unused_md_is_div = ex_md_is_div;
  assign hilo_stall       = id_use_hilo && ex_md_start;
  assign md_busy_int      = 1'b0;
  assign md_done_int      = 1'b0;
`endif

  always_comb begin
    pc_en_int    = 1'b1;
    memwb_en_int = 1'b1;
    ifid         = '{en: 1'b1, clr: 1'b0};
    idex         = '{en: 1'b1, clr: 1'b0};
    exmem        = '{en: 1'b1, clr: 1'b0};
    if (reset) begin
      // keep the defaults
    end else if (dmem_wait) begin
      pc_en_int    = 1'b0;
      memwb_en_int = 1'b0;
      ifid.en      = 1'b0;
      idex.en      = 1'b0;
      exmem.en     = 1'b0;
    end else if (ex_branch_taken) begin
      ifid.clr = 1'b1;
      idex.clr = 1'b1;
    end else if (load_use || hilo_stall) begin
      pc_en_int = 1'b0;
      ifid.en   = 1'b0;
      idex.clr  = 1'b1;
    end
  end

  assign pc_en     = pc_en_int;
  assign ifid_en   = ifid.en;
  assign idex_en   = idex.en;
  assign exmem_en  = exmem.en;
  assign memwb_en  = memwb_en_int;
  assign ifid_clr  = ifid.clr;
  assign idex_clr  = idex.clr;
  assign exmem_clr = exmem.clr;

  logic [REG_AW-1:0] ex_src [2];
  FwdSel             fwd_sel [2];

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      reset                                                          ? FWD_RF    :
      (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src[gi])) ? FWD_EXMEM :
      (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_src[gi])) ? FWD_MEMWB :
                                                                       FWD_RF;
  end

  assign fwd_a   = fwd_sel[0];
  assign fwd_b   = fwd_sel[1];
  assign md_busy = md_busy_int;
  assign md_done = md_done_int;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus random
// traffic, compared each cycle against a cycle-indexed behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 32;
  localparam int REG_AW      = 5;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs, id_use_rt, id_use_hilo;
  logic              ex_reg_write, mem_reg_write, wb_reg_write;
  logic              ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div, dmem_wait;
  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_clr, idex_clr, exmem_clr;
  logic [1:0]        fwd_a, fwd_b;
  logic              md_busy, md_done;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .REG_AW     (REG_AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_use_hilo    (id_use_hilo),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .ex_reg_write   (ex_reg_write),
    .mem_reg_write  (mem_reg_write),
    .wb_reg_write   (wb_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start    (ex_md_start),
    .ex_md_is_div   (ex_md_is_div),
    .dmem_wait      (dmem_wait),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_clr       (ifid_clr),
    .idex_clr       (idex_clr),
    .exmem_clr      (exmem_clr),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .md_busy        (md_busy),
    .md_done        (md_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one outstanding mul/div op described by its issue cycle and latency.
  int cyc      = 0;
  bit op_live  = 1'b0;
  int op_issue = 0;
  int op_len   = 0;
  int busy_seen, done_seen, done_cyc;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_busy();
    return op_live && (cyc > op_issue) && (cyc < op_issue + op_len);
  endfunction

  function automatic bit m_done();
    return op_live && (cyc == op_issue + op_len - 1);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] src);
    if (reset) return 2'b00;
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr}
  function automatic logic [7:0] m_ctrl();
    bit lu, hs;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    hs = id_use_hilo && (ex_md_start || (MD_EN && m_busy()));
    if (reset)           return 8'b11111_000;
    if (dmem_wait)       return 8'b00000_000;
    if (ex_branch_taken) return 8'b11111_110;
    if (lu || hs)        return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  task automatic step(input string label);
    logic [7:0] ctrl;
    #3;
    ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr};
    expect_eq({label, ".ctrl"}, 32'(ctrl), 32'(m_ctrl()));
    expect_eq({label, ".fwd_a"}, 32'(fwd_a), 32'(m_fwd(ex_rs)));
    expect_eq({label, ".fwd_b"}, 32'(fwd_b), 32'(m_fwd(ex_rt)));
    expect_eq({label, ".md_busy"}, 32'(md_busy), 32'(MD_EN && m_busy()));
    expect_eq({label, ".md_done"}, 32'(md_done), 32'(MD_EN && m_done()));
    if (md_busy) busy_seen++;
    if (md_done) begin done_seen++; done_cyc = cyc; end
    $display("cyc %0d %s ctrl=%b fwd=%b/%b busy=%b done=%b",
             cyc, label, ctrl, fwd_a, fwd_b, md_busy, md_done);
    @(posedge clock);
    if (reset) begin
      op_live = 1'b0;
    end else if (MD_EN && !m_busy() && ex_md_start && !dmem_wait && !ex_branch_taken) begin
      op_live  = 1'b1;
      op_issue = cyc;
      op_len   = ex_md_is_div ? DIV_CYCLES : MULT_CYCLES;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_use_hilo = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_md_start = 0; ex_md_is_div = 0; dmem_wait = 0;
  endtask

  task automatic clear_md_stats();
    busy_seen = 0; done_seen = 0; done_cyc = 0;
  endtask

  initial begin
    int issue_at;
    clear_inputs();
    clear_md_stats();
    @(posedge clock);
    #1;

    reset = 1; mem_rd = 3; ex_rs = 3; mem_reg_write = 1; ex_md_start = 1; id_use_hilo = 1;
    step("reset");
    step("reset");
    clear_inputs();
    step("idle");

    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    step("load_use");
    ex_branch_taken = 1;
    step("load_use_branch");
    ex_branch_taken = 0; id_rs = 0; id_rt = 8; id_use_rs = 0; id_use_rt = 1;
    step("load_use_rt");
    ex_rd = 0; id_rt = 0;
    step("load_r0");
    clear_inputs();

    mem_rd = 3; wb_rd = 3; ex_rs = 3; ex_rt = 3; mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_both");
    mem_rd = 0;
    step("fwd_memwb");
    ex_rs = 0;
    step("fwd_rs0");
    clear_inputs();

    // Divide, then mflo waiting in ID until the result is ready.
    clear_md_stats();
    ex_md_start = 1; ex_md_is_div = 1; issue_at = cyc;
    step("div_issue");
    ex_md_start = 0; ex_md_is_div = 0; id_use_hilo = 1;
    for (int i = 0; i < DIV_CYCLES + 1; i++) step("div_mflo");
    expect_eq("div_busy_len", 32'(busy_seen), MD_EN ? 32'(DIV_CYCLES - 1) : 32'd0);
    expect_eq("div_done_count", 32'(done_seen), MD_EN ? 32'd1 : 32'd0);
    expect_eq("div_done_offset", 32'(done_seen != 0 ? done_cyc - issue_at : 0),
              MD_EN ? 32'(DIV_CYCLES - 1) : 32'd0);
    clear_inputs();

    // Divide running through a ten-cycle memory freeze.
    clear_md_stats();
    ex_md_start = 1; ex_md_is_div = 1; issue_at = cyc;
    step("frz_issue");
    ex_md_start = 0; ex_md_is_div = 0; id_use_hilo = 1;
    for (int i = 0; i < 3; i++) step("frz_pre");
    dmem_wait = 1;
    for (int i = 0; i < 10; i++) step("frz_wait");
    dmem_wait = 0;
    for (int i = 0; i < DIV_CYCLES - 12; i++) step("frz_post");
    expect_eq("frz_done_offset", 32'(done_seen != 0 ? done_cyc - issue_at : 0),
              MD_EN ? 32'(DIV_CYCLES - 1) : 32'd0);
    clear_inputs();

    // Multiply for a short-latency case.
    clear_md_stats();
    ex_md_start = 1; issue_at = cyc;
    step("mul_issue");
    ex_md_start = 0;
    for (int i = 0; i < MULT_CYCLES + 1; i++) step("mul_run");
    expect_eq("mul_busy_len", 32'(busy_seen), MD_EN ? 32'(MULT_CYCLES - 1) : 32'd0);

    // Reset in the middle of a divide.
    ex_md_start = 1; ex_md_is_div = 1;
    step("rst_issue");
    ex_md_start = 0; ex_md_is_div = 0;
    for (int i = 0; i < 10; i++) step("rst_run");
    reset = 1;
    step("rst_assert");
    reset = 0; id_use_hilo = 1;
    #3;
    expect_eq("rst_md_busy", 32'(md_busy), 32'd0);
    expect_eq("rst_no_stall", 32'(pc_en), 32'd1);
    #1;
    step("rst_mflo");
    clear_inputs();

    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(49, 0) == 0);
      id_rs           = REG_AW'($urandom_range(7, 0));
      id_rt           = REG_AW'($urandom_range(7, 0));
      ex_rs           = REG_AW'($urandom_range(7, 0));
      ex_rt           = REG_AW'($urandom_range(7, 0));
      ex_rd           = REG_AW'($urandom_range(7, 0));
      mem_rd          = REG_AW'($urandom_range(7, 0));
      wb_rd           = REG_AW'($urandom_range(7, 0));
      id_use_rs       = 1'($urandom);
      id_use_rt       = 1'($urandom);
      id_use_hilo     = ($urandom_range(3, 0) == 0);
      ex_reg_write    = 1'($urandom);
      mem_reg_write   = 1'($urandom);
      wb_reg_write    = 1'($urandom);
      ex_mem_read     = ($urandom_range(2, 0) == 0);
      ex_branch_taken = ($urandom_range(7, 0) == 0);
      dmem_wait       = ($urandom_range(5, 0) == 0);
      ex_md_is_div    = ($urandom_range(3, 0) == 0);
      ex_md_start     = !m_busy() && ($urandom_range(9, 0) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
